pipe_controller: RTL and testbench
==================================

# pipe_controller

Control unit for the 5-stage pipelined ARM-subset datapath. It decodes the instruction in Decode, carries the control bits through Execute, Memory and Writeback pipeline registers, and evaluates the condition field against an architectural NZCV flags register in Execute. Its outputs drive the datapath directly, and it supplies the hazard unit with write-enable and pending-PC status.

## Interface
- No parameters; widths are fixed by the ISA subset.
- clk  in  1  single clock; all registers update on its rising edge.
- reset  in  1  asynchronous, active-high; clears every register in the block.
- InstrD  in  20  instruction bits [31:12] in Decode: cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- ALUFlagsE  in  4  NZCV from the ALU in Execute.
- FlushE  in  1  synchronous clear of the Decode→Execute control register (bubble insertion).
- RegSrcD, ImmSrcD  out  2 each  Decode-stage register-select and extend-select controls.
- ALUSrcE  out  1  Execute-stage immediate-select control.
- ALUControlE  out  2  Execute-stage ALU operation.
- BranchTakenE  out  1  branch taken, resolved in Execute.
- MemWriteM  out  1  data-memory write enable, already condition-gated.
- RegWriteM  out  1  Memory-stage register-write enable, for the hazard unit.
- MemtoRegE  out  1  Execute-stage load indicator, for the hazard unit.
- RegWriteW, MemtoRegW, PCSrcW  out  1 each  Writeback-stage controls.
- PCWrPendingF  out  1  a PC write is in flight in Decode, Execute or Memory.

## Operation
- **Decode.** Decode is combinational on InstrD.
- **Data processing (Op=00).**
  - ALUSrc=Funct[5]; ImmSrc=00; RegSrc=00; RegW=1.
  - cmd=Funct[4:1] selects the ALU operation: ADD 0100→00, SUB 0010→01, AND 0000→10, ORR 1100→11.
  - CMP 1010 uses SUB (01) with RegW=0.
  - Any other cmd gives ALUControl=00 and RegW=0.
  - FlagW[1]=Funct[0]. FlagW[0]=Funct[0] & (ALU operation is ADD or SUB).
- **Memory (Op=01).**
  - Common: ALUSrc=1, ImmSrc=01, ALUControl=00.
  - LDR (Funct[0]=1): RegW=1, MemtoReg=1, RegSrc=00.
  - STR (Funct[0]=0): MemW=1, RegSrc=10.
- **Branch (Op=10).** Branch=1, ALUSrc=1, ImmSrc=10, RegSrc=01, ALUControl=00.
- **Op=11.** All control bits are 0 (no operation).
- **PC write in Decode.** PCSrcD = RegW & (Rd==4'hF).
- **Decode→Execute register.**
  - Contents: RegW, MemW, MemtoReg, PCSrc, Branch, ALUSrc, ALUControl, FlagW, cond.
  - FlushE=1 loads all zeros at the edge.
- **Condition check (Execute).** CondExE is computed from cond against the flags register:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
  - HI C&!Z; LS !C|Z.
  - GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
  - AL 1110 → 1; 1111 → 0.
- **Flags register.**
  - Bits [3:2] (NZ) load from ALUFlagsE[3:2] when FlagW[1] & CondExE.
  - Bits [1:0] (CV) load from ALUFlagsE[1:0] when FlagW[0] & CondExE.
- **Gating in Execute.** RegWrite, MemWrite and PCSrc are ANDed with CondExE before entering the Execute→Memory register. BranchTakenE = BranchE & CondExE.
- **Execute→Memory register:** RegW, MemW, MemtoReg, PCSrc.
- **Memory→Writeback register:** RegW, MemtoReg, PCSrc.
- **Pending PC write.** PCWrPendingF = PCSrcD | PCSrcE | PCSrcM. PCSrcE is taken before condition gating, so the signal is conservative.

## Timing
- Reset: every output driven from a register reads 0, and the flags register is 0000. Decode outputs follow InstrD.
- An instruction's control reaches E one cycle after D, M after two cycles, W after three.
- The flags register updates at the edge that closes E. The next instruction's condition check, in E on the following cycle, sees the new flags; no forwarding path is needed.
- FlushE and a flag-setting instruction in E in the same cycle: the flags update still occurs (it belongs to the older instruction). The incoming bubble carries zeros.
- A flushed (bubble) cond is 0000 (EQ), but all of its write bits are 0, so it has no effect.
- Reset asserted mid-pipeline: all in-flight controls are cleared immediately, without waiting for a clock edge.

## Structure
- Shared package holds:
  - Op encodings (DP/MEM/BR).
  - cmd encodings.
  - ALUControl codes (ADD/SUB/AND/ORR).
  - The 16 condition-code constants.
  - The control-bundle struct for each pipeline stage.
- One sub-module, cond_unit: the flags register plus condition evaluation, producing CondExE.

## Test plan
- **Reset:** assert reset mid-stream → RegWriteW, MemWriteM, PCSrcW, BranchTakenE all 0 asynchronously; flags = 0000.
- **Flag-setting SUB then BEQ:** SUBS with ALUFlagsE=0100 in E, then BEQ (cond 0000) in E → BranchTakenE=1. Repeat with flags 0000 → BranchTakenE=0.
- **LDR:** LDR in D → MemtoRegE=1 one cycle later. RegWriteW=1 and MemtoRegW=1 exactly three cycles after D.
- **Conditional STR with NE while Z=1:** MemWriteM=0 and flags unchanged. The same with Z=0 → MemWriteM=1.
- **Write to PC (ADD with Rd=15):** PCWrPendingF=1 for three cycles, then PCSrcW=1 in the fourth. Asserting FlushE in the cycle it enters E → PCSrcW never rises.
- **Invalid cond 1111 on ADDS:** RegWriteM=0 and flags unchanged.

Source files
------------

// File: rtl/pipe_controller_pkg.sv
// rtl/pipe_controller_pkg.sv - shared encodings and per-stage control bundles for pipe_controller
package pipe_controller_pkg;

    typedef enum logic [1:0] {
        OP_DP   = 2'b00,
        OP_MEM  = 2'b01,
        OP_BR   = 2'b10,
        OP_NONE = 2'b11
    } op_e;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_ORR = 2'b11
    } alu_op_e;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
        COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
        COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
        COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE, COND_NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic       reg_w;
        logic       mem_w;
        logic       mem_to_reg;
        logic       pc_src;
        logic       branch;
        logic       alu_src;
        alu_op_e    alu_control;
        logic [1:0] flag_w;
        cond_e      cond;
    } ctrl_e_t;

    typedef struct packed {
        logic reg_w;
        logic mem_w;
        logic mem_to_reg;
        logic pc_src;
    } ctrl_m_t;

    typedef struct packed {
        logic reg_w;
        logic mem_to_reg;
        logic pc_src;
    } ctrl_w_t;

endpackage

// File: rtl/cond_unit.sv
// rtl/cond_unit.sv - NZCV flags register and Execute-stage condition evaluation
module cond_unit
    import pipe_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] alu_flags,
    input  logic [1:0] flag_w,
    output logic       cond_ex
);

    logic [3:0] flags;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e'(cond))
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = !z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = !c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = !n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = !v;
            COND_HI: cond_ex = c & !z;
            COND_LS: cond_ex = !c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = !z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // NZ and CV halves load independently so logical ops leave C and V alone
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags <= 4'b0000;
        end else begin
            if (flag_w[1] & cond_ex) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] & cond_ex) flags[1:0] <= alu_flags[1:0];
        end
    end

endmodule

// File: rtl/pipe_controller.sv
// rtl/pipe_controller.sv - decode and D/E/M/W control pipeline for the 5-stage ARM-subset datapath
module pipe_controller
    import pipe_controller_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] InstrD,
    input  logic [3:0]  ALUFlagsE,
    input  logic        FlushE,
    output logic [1:0]  RegSrcD,
    output logic [1:0]  ImmSrcD,
    output logic        ALUSrcE,
    output logic [1:0]  ALUControlE,
    output logic        BranchTakenE,
    output logic        MemWriteM,
    output logic        RegWriteM,
    output logic        MemtoRegE,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic        PCSrcW,
    output logic        PCWrPendingF
);

    logic [3:0] cond_d;
    logic [1:0] op_d;
    logic [5:0] funct_d;
    logic [3:0] rd_d;
    logic       unused_rn;

    assign cond_d    = InstrD[19:16];
    assign op_d      = InstrD[15:14];
    assign funct_d   = InstrD[13:8];
    assign rd_d      = InstrD[3:0];
    assign unused_rn = ^InstrD[7:4];

    ctrl_e_t ctrl_d;
    ctrl_e_t ctrl_e;
    ctrl_m_t ctrl_m;
    ctrl_w_t ctrl_w;
    logic    cond_ex_e;

    always_comb begin
        ctrl_d      = '0;
        RegSrcD     = 2'b00;
        ImmSrcD     = 2'b00;
        ctrl_d.cond = cond_e'(cond_d);
        case (op_e'(op_d))
            OP_DP: begin
                ctrl_d.alu_src = funct_d[5];
                case (funct_d[4:1])
                    CMD_ADD: begin ctrl_d.alu_control = ALU_ADD; ctrl_d.reg_w = 1'b1; end
                    CMD_SUB: begin ctrl_d.alu_control = ALU_SUB; ctrl_d.reg_w = 1'b1; end
                    CMD_AND: begin ctrl_d.alu_control = ALU_AND; ctrl_d.reg_w = 1'b1; end
                    CMD_ORR: begin ctrl_d.alu_control = ALU_ORR; ctrl_d.reg_w = 1'b1; end
                    CMD_CMP: ctrl_d.alu_control = ALU_SUB;
                    default: ctrl_d.alu_control = ALU_ADD;
                endcase
                // only arithmetic ops produce meaningful C and V
                ctrl_d.flag_w = {funct_d[0],
                                 funct_d[0] & (ctrl_d.alu_control == ALU_ADD ||
                                               ctrl_d.alu_control == ALU_SUB)};
            end
            OP_MEM: begin
                ctrl_d.alu_src = 1'b1;
                ImmSrcD        = 2'b01;
                if (funct_d[0]) begin
                    ctrl_d.reg_w      = 1'b1;
                    ctrl_d.mem_to_reg = 1'b1;
                end else begin
                    ctrl_d.mem_w = 1'b1;
                    RegSrcD      = 2'b10;
                end
            end
            OP_BR: begin
                ctrl_d.branch  = 1'b1;
                ctrl_d.alu_src = 1'b1;
                ImmSrcD        = 2'b10;
                RegSrcD        = 2'b01;
            end
            default: ;
        endcase
        ctrl_d.pc_src = ctrl_d.reg_w & (rd_d == 4'hF);
    end

    cond_unit u_cond (
        .clk       (clk),
        .reset     (reset),
        .cond      (ctrl_e.cond),
        .alu_flags (ALUFlagsE),
        .flag_w    (ctrl_e.flag_w),
        .cond_ex   (cond_ex_e)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e <= '0;
            ctrl_m <= '0;
            ctrl_w <= '0;
        end else begin
            if (FlushE) ctrl_e <= '0;
            else        ctrl_e <= ctrl_d;
            ctrl_m.reg_w      <= ctrl_e.reg_w & cond_ex_e;
            ctrl_m.mem_w      <= ctrl_e.mem_w & cond_ex_e;
            ctrl_m.mem_to_reg <= ctrl_e.mem_to_reg;
            ctrl_m.pc_src     <= ctrl_e.pc_src & cond_ex_e;
            ctrl_w.reg_w      <= ctrl_m.reg_w;
            ctrl_w.mem_to_reg <= ctrl_m.mem_to_reg;
            ctrl_w.pc_src     <= ctrl_m.pc_src;
        end
    end

    assign ALUSrcE      = ctrl_e.alu_src;
    assign ALUControlE  = ctrl_e.alu_control;
    assign MemtoRegE    = ctrl_e.mem_to_reg;
    assign BranchTakenE = ctrl_e.branch & cond_ex_e;
    assign MemWriteM    = ctrl_m.mem_w;
    assign RegWriteM    = ctrl_m.reg_w;
    assign RegWriteW    = ctrl_w.reg_w;
    assign MemtoRegW    = ctrl_w.mem_to_reg;
    assign PCSrcW       = ctrl_w.pc_src;
    // ungated E-stage pc_src keeps this conservative for the hazard unit
    assign PCWrPendingF = ctrl_d.pc_src | ctrl_e.pc_src | ctrl_m.pc_src;

endmodule

// File: tb/tb_pipe_controller.sv
// tb/tb_pipe_controller.sv - scoreboard bench for pipe_controller with directed instruction vectors
module tb_pipe_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] InstrD;
    logic [3:0]  ALUFlagsE;
    logic        FlushE;
    logic [1:0]  RegSrcD, ImmSrcD, ALUControlE;
    logic        ALUSrcE, BranchTakenE, MemWriteM, RegWriteM, MemtoRegE;
    logic        RegWriteW, MemtoRegW, PCSrcW, PCWrPendingF;

    pipe_controller dut (
        .clk          (clk),
        .reset        (reset),
        .InstrD       (InstrD),
        .ALUFlagsE    (ALUFlagsE),
        .FlushE       (FlushE),
        .RegSrcD      (RegSrcD),
        .ImmSrcD      (ImmSrcD),
        .ALUSrcE      (ALUSrcE),
        .ALUControlE  (ALUControlE),
        .BranchTakenE (BranchTakenE),
        .MemWriteM    (MemWriteM),
        .RegWriteM    (RegWriteM),
        .MemtoRegE    (MemtoRegE),
        .RegWriteW    (RegWriteW),
        .MemtoRegW    (MemtoRegW),
        .PCSrcW       (PCSrcW),
        .PCWrPendingF (PCWrPendingF)
    );

    always #5 clk = ~clk;

    typedef enum int {
        S_BT, S_MWM, S_RWM, S_MTRE, S_RWW, S_MTRW, S_PCW, S_PEND,
        S_FLAGS, S_ALUC, S_ALUSRC, S_REGSRC, S_IMMSRC
    } sig_e;

    typedef struct {
        int         cyc;
        sig_e       sig;
        logic [3:0] val;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    localparam logic [19:0] NOP = 20'hEC000;

    function automatic logic [19:0] mk(input logic [3:0] cond, input logic [1:0] op,
                                       input logic [5:0] funct, input logic [3:0] rd);
        return {cond, op, funct, 4'h0, rd};
    endfunction

    function automatic logic [3:0] sample(input sig_e s);
        case (s)
            S_BT:     return {3'b0, BranchTakenE};
            S_MWM:    return {3'b0, MemWriteM};
            S_RWM:    return {3'b0, RegWriteM};
            S_MTRE:   return {3'b0, MemtoRegE};
            S_RWW:    return {3'b0, RegWriteW};
            S_MTRW:   return {3'b0, MemtoRegW};
            S_PCW:    return {3'b0, PCSrcW};
            S_PEND:   return {3'b0, PCWrPendingF};
            S_FLAGS:  return dut.u_cond.flags;
            S_ALUC:   return {2'b0, ALUControlE};
            S_ALUSRC: return {3'b0, ALUSrcE};
            S_REGSRC: return {2'b0, RegSrcD};
            S_IMMSRC: return {2'b0, ImmSrcD};
            default:  return 4'hx;
        endcase
    endfunction

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_at(input int d, input sig_e s, input logic [3:0] v, input string n);
        exp_t e;
        e.cyc = cyc + d; e.sig = s; e.val = v; e.name = n;
        q.push_back(e);
    endtask

    task automatic step(input logic [19:0] ins, input logic [3:0] fl, input logic fls);
        @(posedge clk);
        #1;
        InstrD = ins; ALUFlagsE = fl; FlushE = fls;
        cyc++;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc == cyc) begin
                    chk(q[i].name, sample(q[i].sig), q[i].val);
                    q.delete(i);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [19:0] subs, beq, ldr, strne, add_pc, adds_nv, adds, orr_i, and_r, cmp, str_al, b_al;
        subs    = mk(4'hE, 2'b00, 6'b000101, 4'h1);
        beq     = mk(4'h0, 2'b10, 6'b000000, 4'h0);
        ldr     = mk(4'hE, 2'b01, 6'b000001, 4'h2);
        strne   = mk(4'h1, 2'b01, 6'b000000, 4'h3);
        add_pc  = mk(4'hE, 2'b00, 6'b001000, 4'hF);
        adds_nv = mk(4'hF, 2'b00, 6'b001001, 4'h4);
        adds    = mk(4'hE, 2'b00, 6'b001001, 4'h4);
        orr_i   = mk(4'hE, 2'b00, 6'b111000, 4'h5);
        and_r   = mk(4'hE, 2'b00, 6'b000000, 4'h6);
        cmp     = mk(4'hE, 2'b00, 6'b010101, 4'h0);
        str_al  = mk(4'hE, 2'b01, 6'b000000, 4'h3);
        b_al    = mk(4'hE, 2'b10, 6'b000000, 4'h0);

        reset = 1'b1; InstrD = ldr; ALUFlagsE = 4'hF; FlushE = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_regwritew", {3'b0, RegWriteW}, 4'h0);
        chk("rst_memtorege", {3'b0, MemtoRegE}, 4'h0);
        chk("rst_flags", dut.u_cond.flags, 4'h0);
        chk("rst_decode_immsrc", {2'b0, ImmSrcD}, 4'h1);
        InstrD = NOP; ALUFlagsE = 4'h0;
        reset = 1'b0;

        // SUBS sets Z, then BEQ taken; repeat with Z clear
        step(subs, 4'h0, 0);   expect_at(0, S_REGSRC, 4'h0, "subs_regsrc");
                               expect_at(1, S_ALUC, 4'h1, "subs_aluc");
                               expect_at(1, S_ALUSRC, 4'h0, "subs_alusrc");
        step(beq, 4'h4, 0);    expect_at(0, S_REGSRC, 4'h1, "beq_regsrc");
                               expect_at(0, S_IMMSRC, 4'h2, "beq_immsrc");
                               expect_at(0, S_BT, 4'h0, "subs_no_branch");
                               expect_at(1, S_BT, 4'h1, "beq_taken_z1");
                               expect_at(1, S_FLAGS, 4'h4, "subs_flags_z");
        step(NOP, 4'hF, 0);    expect_at(1, S_FLAGS, 4'h4, "beq_no_flag_write");
                               expect_at(1, S_BT, 4'h0, "nop_no_branch");
        step(subs, 4'h0, 0);
        step(beq, 4'h0, 0);
        step(NOP, 4'hF, 0);    expect_at(0, S_BT, 4'h0, "beq_not_taken_z0");
                               expect_at(0, S_FLAGS, 4'h0, "subs_flags_clear");

        // LDR latency
        step(ldr, 4'h0, 0);    expect_at(0, S_IMMSRC, 4'h1, "ldr_immsrc");
                               expect_at(1, S_MTRE, 4'h1, "ldr_memtorege");
                               expect_at(1, S_ALUSRC, 4'h1, "ldr_alusrc");
                               expect_at(2, S_RWM, 4'h1, "ldr_regwritem");
                               expect_at(2, S_RWW, 4'h0, "ldr_regwritew_early");
                               expect_at(3, S_RWW, 4'h1, "ldr_regwritew");
                               expect_at(3, S_MTRW, 4'h1, "ldr_memtoregw");
                               expect_at(4, S_RWW, 4'h0, "ldr_regwritew_late");
        step(NOP, 4'h0, 0);
        step(NOP, 4'h0, 0);
        step(NOP, 4'h0, 0);

        // STRNE with Z=1 suppressed, with Z=0 performed
        step(subs, 4'h0, 0);
        step(strne, 4'h4, 0);  expect_at(0, S_REGSRC, 4'h2, "str_regsrc");
        step(NOP, 4'h0, 0);    expect_at(1, S_MWM, 4'h0, "strne_z1_memwrite");
                               expect_at(1, S_FLAGS, 4'h4, "strne_flags_kept");
        step(subs, 4'h0, 0);
        step(strne, 4'h0, 0);
        step(NOP, 4'h4, 0);    expect_at(1, S_MWM, 4'h1, "strne_z0_memwrite");
                               expect_at(1, S_FLAGS, 4'h0, "strne_z0_flags");
        step(NOP, 4'h0, 0);

        // write to PC, then the same instruction flushed
        step(add_pc, 4'h0, 0); expect_at(0, S_PEND, 4'h1, "pc_pend_d");
                               expect_at(1, S_PEND, 4'h1, "pc_pend_e");
                               expect_at(2, S_PEND, 4'h1, "pc_pend_m");
                               expect_at(2, S_PCW, 4'h0, "pc_pcsrcw_early");
                               expect_at(3, S_PEND, 4'h0, "pc_pend_w");
                               expect_at(3, S_PCW, 4'h1, "pc_pcsrcw");
        step(NOP, 4'h0, 0);
        step(NOP, 4'h0, 0);
        step(NOP, 4'h0, 0);
        step(add_pc, 4'h0, 1); expect_at(0, S_PEND, 4'h1, "flush_pend_d");
                               expect_at(1, S_PEND, 4'h0, "flush_pend_e");
                               expect_at(2, S_PCW, 4'h0, "flush_pcsrcw_a");
                               expect_at(3, S_PCW, 4'h0, "flush_pcsrcw_b");
        step(NOP, 4'h0, 0);
        step(NOP, 4'h0, 0);
        step(NOP, 4'h0, 0);

        // flush does not cancel the older instruction's flag update
        step(subs, 4'h0, 0);
        step(NOP, 4'h4, 1);    expect_at(1, S_FLAGS, 4'h4, "flush_flags_update");
                               expect_at(1, S_RWM, 4'h1, "flush_older_regwritem");
        step(NOP, 4'h0, 0);

        // cond 1111 never executes; AL does
        step(adds_nv, 4'h0, 0);
        step(NOP, 4'hB, 0);    expect_at(1, S_RWM, 4'h0, "nv_regwritem");
                               expect_at(1, S_FLAGS, 4'h4, "nv_flags_kept");
        step(NOP, 4'h0, 0);
        step(adds, 4'h0, 0);
        step(NOP, 4'hB, 0);    expect_at(1, S_RWM, 4'h1, "al_regwritem");
                               expect_at(1, S_FLAGS, 4'hB, "al_flags");

        // remaining ALU encodings and CMP
        step(orr_i, 4'h0, 0);  expect_at(1, S_ALUC, 4'h3, "orr_aluc");
                               expect_at(1, S_ALUSRC, 4'h1, "orr_alusrc");
        step(and_r, 4'h0, 0);  expect_at(1, S_ALUC, 4'h2, "and_aluc");
                               expect_at(1, S_ALUSRC, 4'h0, "and_alusrc");
        step(cmp, 4'h0, 0);    expect_at(1, S_ALUC, 4'h1, "cmp_aluc");
        step(NOP, 4'h8, 0);    expect_at(1, S_RWM, 4'h0, "cmp_regwritem");
                               expect_at(1, S_FLAGS, 4'h8, "cmp_flags");
        step(NOP, 4'h0, 0);

        // fill E/M/W, then assert reset between edges
        step(add_pc, 4'h0, 0);
        step(str_al, 4'h0, 0);
        step(b_al, 4'h0, 0);
        step(NOP, 4'h0, 0);    expect_at(0, S_RWW, 4'h1, "pre_rst_regwritew");
                               expect_at(0, S_PCW, 4'h1, "pre_rst_pcsrcw");
                               expect_at(0, S_MWM, 4'h1, "pre_rst_memwritem");
                               expect_at(0, S_BT, 4'h1, "pre_rst_branch");
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        chk("async_regwritew", {3'b0, RegWriteW}, 4'h0);
        chk("async_memwritem", {3'b0, MemWriteM}, 4'h0);
        chk("async_pcsrcw", {3'b0, PCSrcW}, 4'h0);
        chk("async_branch", {3'b0, BranchTakenE}, 4'h0);
        chk("async_flags", dut.u_cond.flags, 4'h0);
        @(posedge clk); #1;
        chk("queue_drained", {3'b0, q.size() == 0}, 4'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
